// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
//   Shared definitions for the MIPS32 pipeline: instruction width, opcode
//   constants, instruction-type codes, the fetch-queue entry layout and small
//   decode helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package mips32_pkg;

  localparam int INSTR_W = 32;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } instr_type_e;

  // One fetch-queue entry: instruction word plus its next-PC.
  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] npc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[31:26] == OP_HLT;
  endfunction

  function automatic instr_type_e instr_type(input logic [5:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return RR_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// -----------------------------------------------------------------------------
// mips32_fetch_fifo
//   DEPTH-entry queue of {ir, npc} words between the fetch logic and decode.
//   Wrap-around read/write pointers, occupancy count, synchronous flush.
//   Ports:
//     clk1, rst_n      clock / asynchronous active-low reset
//     i_push           write i_wr_data at the tail
//     i_pop            drop the head entry
//     i_flush          empty the queue (wins over push and pop)
//     i_wr_data        entry to write
//     o_rd_data        current head entry (combinational read)
//     o_count          number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module mips32_fetch_fifo
  import mips32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_wr_data,
  output fetch_entry_t     o_rd_data,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full queue can still accept a word in the cycle its head leaves.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Storage carries no reset; stale slots are never presented as valid.
  always_ff @(posedge clk1) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/mips32_fetch_unit.sv
// -----------------------------------------------------------------------------
// mips32_fetch_unit
//   Prefetching instruction-fetch stage. Issues one-word reads to instruction
//   memory, queues {IR, NPC} pairs and hands them to decode over valid/ready.
//   A redirect flushes the queue, drops any in-flight read and restarts at the
//   target. Fetch stops once an HLT word has been queued.
//   Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushed.
//   Ports:
//     clk1, rst_n                 clock / asynchronous active-low reset
//     imem_req, imem_addr         read strobe and word address (registered PC)
//     imem_rdata                  read data, valid one cycle after imem_req
//     id_valid, id_ready          decode handshake
//     id_ir, id_npc               head instruction and its next-PC
//     redirect_valid, redirect_pc taken-branch restart
//     halt_seen                   HLT queued or consumed; fetch stopped
//     perf_fetched, perf_flushed  (FETCH_PERF_EN only) saturating counters
// -----------------------------------------------------------------------------
module mips32_fetch_unit
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_ir,
  output logic [31:0]       id_npc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              halt_seen
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_inflight;
  logic              r_halt;
  logic [31:0]       r_hold_ir;
  logic [31:0]       r_hold_npc;

  logic [CNT_W-1:0]  w_count;
  logic [SUM_W-1:0]  w_occupancy;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_wr_entry;
  fetch_entry_t      w_head;

  // Reserve a queue slot for every outstanding read so a response never
  // needs back-pressure. Gating with rst_n keeps the strobe low in reset.
  assign w_occupancy = SUM_W'(w_count) + SUM_W'(r_inflight);
  assign w_issue     = rst_n && !r_halt && !redirect_valid &&
                       (w_occupancy < SUM_W'(DEPTH));

  // Once an HLT is queued, the word fetched right behind it is dropped.
  assign w_push = r_inflight && !redirect_valid && !r_halt;
  assign w_pop  = id_valid && id_ready && !redirect_valid;

  assign w_wr_entry.ir  = imem_rdata;
  assign w_wr_entry.npc = 32'(r_req_addr) + 32'd1;

  mips32_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (redirect_valid),
    .i_wr_data (w_wr_entry),
    .o_rd_data (w_head),
    .o_count   (w_count)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= ADDR_W'(RESET_PC);
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_halt     <= 1'b0;
      r_hold_ir  <= '0;
      r_hold_npc <= '0;
    end else begin
      r_inflight <= w_issue;
      r_hold_ir  <= id_ir;
      r_hold_npc <= id_npc;
      if (redirect_valid) begin
        r_pc   <= redirect_pc[ADDR_W-1:0];
        r_halt <= 1'b0;
      end else begin
        if (w_issue) begin
          r_pc       <= r_pc + ADDR_W'(1);
          r_req_addr <= r_pc;
        end
        if (w_push && is_halt(imem_rdata)) begin
          r_halt <= 1'b1;
        end
      end
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign id_valid  = (w_count != '0);
  // While empty, the last presented word is held rather than a stale slot.
  assign id_ir     = id_valid ? w_head.ir  : r_hold_ir;
  assign id_npc    = id_valid ? w_head.npc : r_hold_npc;
  assign halt_seen = r_halt;

  if (ADDR_W < 32) begin : g_pc_upper
    logic w_unused_pc_upper;
    assign w_unused_pc_upper = ^redirect_pc[31:ADDR_W];
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;
  logic [32:0] w_fetched_sum;
  logic [32:0] w_flushed_sum;

  assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_push);
  // A redirect discards every queued entry plus the outstanding read.
  assign w_flushed_sum = {1'b0, r_perf_flushed} +
                         (redirect_valid ? (33'(w_count) + 33'(r_inflight)) : 33'd0);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      r_perf_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
      r_perf_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_mips32_fetch_unit
//   Bench for the fetch stage. The reference model is the instruction stream
//   itself: after a reset or redirect to address A, decode must see
//   mem[A], mem[A+1], ... (address wrapping at 1024, npc = address+1) up to and
//   including the first HLT word, and nothing after it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips32_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int MEM_N  = 1024;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_seen;

  mips32_fetch_unit #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (0)
  ) dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_ir          (id_ir),
    .id_npc         (id_npc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_seen      (halt_seen)
  );

  always #5 clk1 = ~clk1;

  // Instruction memory: registered read, junk when not strobed.
  logic [31:0] mem [MEM_N];
  always @(posedge clk1) imem_rdata <= imem_req ? mem[imem_addr] : 32'h0BAD_0BAD;

  int n_err = 0;
  int n_chk = 0;

  // Stream model state
  int unsigned exp_addr = 0;
  bit          exp_halted = 0;
  // Previous-cycle observation (stall stability)
  bit          p_valid = 0, p_pop = 0, p_redir = 0;
  logic [31:0] p_ir, p_npc;
  // Last observed pop
  bit          got_pop = 0;
  logic [31:0] pop_ir, pop_npc;

  function automatic bit is_hlt(input logic [31:0] w);
    return w[31:26] == 6'b111111;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the falling edge: compares this cycle against the stream model.
  task automatic observe();
    got_pop = 0;
    if (exp_halted) chk("halt_seen_after_hlt", 32'(halt_seen), 32'd1);
    if (halt_seen) chk("no_req_when_halted", 32'(imem_req), 32'd0);
    if (p_valid && !p_pop && !p_redir) begin
      chk("stall_valid", 32'(id_valid), 32'd1);
      chk("stall_ir", id_ir, p_ir);
      chk("stall_npc", id_npc, p_npc);
    end
    if (redirect_valid) begin
      exp_addr   = redirect_pc % MEM_N;
      exp_halted = 0;
      $display("redirect pc=%h", redirect_pc);
    end else if (id_valid && id_ready) begin
      got_pop = 1;
      pop_ir  = id_ir;
      pop_npc = id_npc;
      $display("pop ir=%h npc=%0d model_addr=%0d", id_ir, id_npc, exp_addr);
      if (exp_halted) begin
        chk("pop_after_hlt", 32'(id_valid), 32'd0);
      end else begin
        chk("pop_ir", id_ir, mem[exp_addr]);
        chk("pop_npc", id_npc, exp_addr + 1);
        if (is_hlt(mem[exp_addr])) exp_halted = 1;
        exp_addr = (exp_addr + 1) % MEM_N;
      end
    end
    p_valid = id_valid;
    p_pop   = id_valid && id_ready;
    p_redir = redirect_valid;
    p_ir    = id_ir;
    p_npc   = id_npc;
  endtask

  task automatic tick();
    @(negedge clk1);
    observe();
    @(posedge clk1);
    #1;
  endtask

  task automatic model_reset();
    exp_addr   = 0;
    exp_halted = 0;
    p_valid    = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ir", id_ir, 32'd0);
    chk("rst_npc", id_npc, 32'd0);
    chk("rst_halt", 32'(halt_seen), 32'd0);
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_pop(input int budget, input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!got_pop && n < budget);
    if (!got_pop) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no pop within %0d cycles", name, budget);
    end
  endtask

  // Redirect for one cycle; afterwards the queue is empty, halt is clear and
  // the target is requested in the very next cycle.
  task automatic apply_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_flushed", 32'(id_valid), 32'd0);
    chk("redir_halt_clr", 32'(halt_seen), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", 32'(imem_addr), target % MEM_N);
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } t1_vec_t;

  typedef struct {
    logic [31:0] target;
    int          stall;
    logic [31:0] exp_ir;
    logic [31:0] exp_npc;
  } redir_vec_t;

  t1_vec_t    t1 [4];
  redir_vec_t rv [5];

  initial begin
    int n;
    int cnt;
    bit found;
    logic [31:0] w;
    logic [31:0] tgt;
    int sel;

    for (int a = 0; a < MEM_N; a++) begin
      w = $urandom;
      if (is_hlt(w)) w[31:26] = 6'b001010;
      mem[a] = w;
    end
    mem[0]   = 32'h2801000a;
    mem[1]   = 32'h28020014;
    mem[2]   = 32'h28030019;
    mem[3]   = 32'hfc000000;
    mem[300] = 32'hfc00012c;
    mem[700] = 32'hfc000001;

    t1[0] = '{32'h2801000a, 32'd1};
    t1[1] = '{32'h28020014, 32'd2};
    t1[2] = '{32'h28030019, 32'd3};
    t1[3] = '{32'hfc000000, 32'd4};

    rv[0] = '{32'd20,        6, mem[20],      32'd21};
    rv[1] = '{32'd1023,      0, mem[1023],    32'd1024};
    rv[2] = '{32'hABCD_E405, 3, mem[5],       32'd6};
    rv[3] = '{32'd3,         2, 32'hfc000000, 32'd4};
    rv[4] = '{32'd300,       8, 32'hfc00012c, 32'd301};

    #1;
    // 1. Straight-line program ending in HLT
    do_reset();
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_pop(20, "t1_wait", n);
      if (k == 0) chk("t1_latency", 32'(n), 32'd3);
      chk("t1_ir", pop_ir, t1[k].ir);
      chk("t1_npc", pop_npc, t1[k].npc);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t1_no_req", 32'(imem_req), 32'd0);
    end
    chk("t1_halt", 32'(halt_seen), 32'd1);
    chk("t1_drained", 32'(id_valid), 32'd0);

    // 2. Decode stall fills the queue, release drains it back-to-back
    id_ready = 1'b0;
    apply_redirect(32'd40);
    repeat (10) tick();
    chk("t2_valid", 32'(id_valid), 32'd1);
    chk("t2_full_noreq", 32'(imem_req), 32'd0);
    chk("t2_head_ir", id_ir, mem[40]);
    chk("t2_head_npc", id_npc, 32'd41);
    id_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (got_pop) cnt++;
    end
    chk("t2_drain_count", 32'(cnt), 32'(DEPTH));

    // 3. Redirect while the queue is at capacity with a read in flight
    id_ready = 1'b0;
    repeat (8) tick();
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    chk("t3_slot_req", 32'(imem_req), 32'd1);
    tick();
    chk("t3_inflight_full", 32'(imem_req), 32'd0);
    apply_redirect(32'd20);
    id_ready = 1'b1;
    wait_pop(10, "t3_wait", n);
    chk("t3_ir", pop_ir, mem[20]);
    chk("t3_npc", pop_npc, 32'd21);

    // Redirect table
    for (int r = 0; r < 5; r++) begin
      id_ready = 1'b0;
      repeat (rv[r].stall) tick();
      apply_redirect(rv[r].target);
      id_ready = 1'b1;
      wait_pop(10, "tab_wait", n);
      $display("vector %0d target=%h ir=%h npc=%0d", r, rv[r].target, pop_ir, pop_npc);
      chk("tab_ir", pop_ir, rv[r].exp_ir);
      chk("tab_npc", pop_npc, rv[r].exp_npc);
    end

    // 4. Address wrap at the top of memory
    id_ready = 1'b0;
    apply_redirect(32'd1023);
    tick();
    chk("t4_addr0", 32'(imem_addr), 32'd0);
    tick();
    chk("t4_addr1", 32'(imem_addr), 32'd1);
    id_ready = 1'b1;
    wait_pop(10, "t4_wait", n);
    chk("t4_npc_a", pop_npc, 32'd1024);
    wait_pop(10, "t4_wait", n);
    chk("t4_npc_b", pop_npc, 32'd1);
    wait_pop(10, "t4_wait", n);
    chk("t4_npc_c", pop_npc, 32'd2);

    // 5. Reset asserted while a read response is on the bus
    id_ready = 1'b0;
    apply_redirect(32'd100);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_valid", 32'(id_valid), 32'd0);
    chk("t5_ir", id_ir, 32'd0);
    chk("t5_npc", id_npc, 32'd0);
    chk("t5_halt", 32'(halt_seen), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    id_ready = 1'b1;
    wait_pop(10, "t5_wait", n);
    chk("t5_latency", 32'(n), 32'd3);
    chk("t5_restart_ir", pop_ir, 32'h2801000a);
    chk("t5_restart_npc", pop_npc, 32'd1);

    // 6. Redirect coinciding with a pop and the HLT push
    apply_redirect(32'd0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (imem_rdata == 32'hfc000000 && id_valid) found = 1;
    end
    chk("t6_found", 32'(found), 32'd1);
    apply_redirect(32'd50);
    wait_pop(10, "t6_wait", n);
    chk("t6_ir", pop_ir, mem[50]);
    chk("t6_npc", pop_npc, 32'd51);

    // Randomized traffic against the stream model
    for (int c = 0; c < 1500; c++) begin
      id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) begin
        sel = $urandom_range(3);
        case (sel)
          0:       tgt = 32'($urandom_range(3));
          1:       tgt = 32'(1020 + $urandom_range(3));
          2:       tgt = 32'(296 + $urandom_range(4));
          default: tgt = $urandom;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
